// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
//
// Sequential signed 64x64 multiplier controller (low 64-bit result). All
// 64-bit additions go through an external shared adder (add_a/add_b in,
// add_sum back). Operand magnitudes are formed with that adder (~x + 1). A
// 64-step shift-add loop runs on the magnitudes. The sign is then applied
// with one more pass through the adder.
//
// Ports
//   clk      in   1   clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   request; operands latched when accepted (IDLE/DONE)
//   op_a     in  64   signed multiplicand
//   op_b     in  64   signed multiplier
//   add_a    out 64   operand A to shared adder (0 when not in use)
//   add_b    out 64   operand B to shared adder (0 when not in use)
//   add_sum  in  64   sum from shared adder, carry-in 0
//   add_cf   in   3   adder flags {OF,SF,ZF}, debug only
//   busy     out  1   sequence in progress
//   done     out  1   one-cycle completion pulse
//   product  out 64   low 64 bits of op_a*op_b, held until next DONE
//   cf       out  3   {OF, SF, ZF} of product, held until next DONE
//
// Build option
//   MUL_SKIP_ZERO_EN : when defined, a zero operand at acceptance jumps
//                      straight to DONE with product=0, cf=3'b001.
// -----------------------------------------------------------------------------
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// ABS_A | |a| through the shared adder
// ABS_B | |b| through the shared adder, result sign recorded
// RUN   | 64 shift-add steps, one per cycle
// NEG   | apply sign to low half, compute flags
// DONE  | done pulse, product/cf valid; may accept a new start
// -----------------------------------------------------------------------------
module mul_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    output logic [63:0] add_a,
    output logic [63:0] add_b,
    input  logic [63:0] add_sum,
    input  logic [2:0]  add_cf,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic [2:0]  cf
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS_A = 3'd1,
        ABS_B = 3'd2,
        RUN   = 3'd3,
        NEG   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_a;        // multiplicand, then |a|
    logic [63:0] r_b;        // multiplier, then |b|, shifted right in RUN
    logic [63:0] r_p_hi;
    logic [63:0] r_p_lo;
    logic        r_sign_a;
    logic        r_neg;
    logic [5:0]  r_cnt;      // RUN steps remaining minus one
    logic [63:0] r_product;
    logic [2:0]  r_cf;

    logic        w_accept;
    logic        w_skip;
    logic        w_carry;
    logic [63:0] w_result;
    logic        w_of;
    logic        w_zf;

    // Adder flags are only brought in for debug visibility.
    logic        w_unused_add_cf;
    assign w_unused_add_cf = ^add_cf;

`ifdef MUL_SKIP_ZERO_EN
    logic        w_zero_op;
    assign w_zero_op = (op_a == 64'd0) || (op_b == 64'd0);
`endif

    // Unsigned carry-out of the shared adder (carry-in is fixed 0), rebuilt
    // from the operand and sum MSBs because the adder does not export it.
    assign w_carry = (add_a[63] & add_b[63]) |
                     ((add_a[63] | add_b[63]) & ~add_sum[63]);

    assign w_result = r_neg ? add_sum : r_p_lo;
    assign w_zf     = (w_result == 64'd0);

    // The magnitude product overflows when it exceeds 2^63-1 (positive) or
    // 2^63 (negative). 2^63 itself is legal as -2^63.
    assign w_of = (|r_p_hi) |
                  (~r_neg & r_p_lo[63]) |
                  (r_neg & r_p_lo[63] & (|r_p_lo[62:0]));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_skip      = 1'b0;
        add_a       = 64'd0;
        add_b       = 64'd0;
        busy        = 1'b0;
        done        = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ABS_A;
`ifdef MUL_SKIP_ZERO_EN
                    if (w_zero_op) begin
                        w_skip      = 1'b1;
                        w_state_nxt = DONE;
                    end
`endif
                end
            end

            ABS_A: begin
                busy        = 1'b1;
                add_a       = r_a[63] ? ~r_a : r_a;
                add_b       = {63'd0, r_a[63]};
                w_state_nxt = ABS_B;
            end

            ABS_B: begin
                busy        = 1'b1;
                add_a       = r_b[63] ? ~r_b : r_b;
                add_b       = {63'd0, r_b[63]};
                w_state_nxt = RUN;
            end

            RUN: begin
                busy  = 1'b1;
                add_a = r_p_hi;
                add_b = r_b[0] ? r_a : 64'd0;
                if (r_cnt == 6'd0) begin
                    w_state_nxt = NEG;
                end
            end

            NEG: begin
                busy = 1'b1;
                if (r_neg) begin
                    add_a = ~r_p_lo;
                    add_b = 64'd1;
                end
                w_state_nxt = DONE;
            end

            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ABS_A;
`ifdef MUL_SKIP_ZERO_EN
                    if (w_zero_op) begin
                        w_skip      = 1'b1;
                        w_state_nxt = DONE;
                    end
`endif
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= 64'd0;
            r_b       <= 64'd0;
            r_p_hi    <= 64'd0;
            r_p_lo    <= 64'd0;
            r_sign_a  <= 1'b0;
            r_neg     <= 1'b0;
            r_cnt     <= 6'd0;
            r_product <= 64'd0;
            r_cf      <= 3'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_a      <= op_a;
                r_b      <= op_b;
                r_p_hi   <= 64'd0;
                r_p_lo   <= 64'd0;
                r_sign_a <= 1'b0;
                r_neg    <= 1'b0;
                r_cnt    <= 6'd0;
            end

            if (w_skip) begin
                r_product <= 64'd0;
                r_cf      <= 3'b001;
            end

            case (r_state)
                ABS_A: begin
                    r_a      <= add_sum;
                    // Keep the sign: |-2^63| still has bit 63 set.
                    r_sign_a <= r_a[63];
                end

                ABS_B: begin
                    r_b   <= add_sum;
                    r_neg <= r_sign_a ^ r_b[63];
                    r_cnt <= 6'd63;
                end

                RUN: begin
                    r_p_hi <= {w_carry, add_sum[63:1]};
                    r_p_lo <= {add_sum[0], r_p_lo[63:1]};
                    r_b    <= {1'b0, r_b[63:1]};
                    r_cnt  <= r_cnt - 6'd1;
                end

                NEG: begin
                    r_product <= w_result;
                    r_cf      <= {w_of, w_result[63], w_zf};
                end

                default: begin
                end
            endcase
        end
    end

    assign product = r_product;
    assign cf      = r_cf;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_ctrl
//
// Bench for mul_seq_ctrl. It supplies the shared adder behaviourally. A
// transaction model computes the expected result from a 128-bit signed
// multiply and predicts when done appears. Latency is counted in rising edges
// with the accepting edge as edge 1, so done is visible after edge 68 (or
// edge 1 for a skipped zero operand). A negedge process compares the DUT
// against the model every cycle. Directed runs pin literal values.
// -----------------------------------------------------------------------------
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] add_a;
    logic [63:0] add_b;
    logic [63:0] add_sum;
    logic [2:0]  add_cf;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [2:0]  cf;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MUL_SKIP_ZERO_EN
    localparam int LAT_ZERO = 1;
`else
    localparam int LAT_ZERO = 68;
`endif
    localparam int LAT_FULL = 68;

    mul_seq_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_sum (add_sum),
        .add_cf  (add_cf),
        .busy    (busy),
        .done    (done),
        .product (product),
        .cf      (cf)
    );

    // Shared adder: plain 64-bit add with carry-in 0.
    assign add_sum = add_a + add_b;
    assign add_cf  = {(add_a[63] == add_b[63]) && (add_sum[63] != add_a[63]),
                      add_sum[63], add_sum == 64'd0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic logic [63:0] mdl_prod(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] full;
        full = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        return full[63:0];
    endfunction

    function automatic logic [2:0] mdl_cf(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] full;
        logic                of;
        full = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        of   = (full[127:63] != {65{full[63]}});
        return {of, full[63], full[63:0] == 64'd0};
    endfunction

    function automatic int mdl_lat(input logic [63:0] a, input logic [63:0] b);
        if (a == 64'd0 || b == 64'd0) return LAT_ZERO;
        return LAT_FULL;
    endfunction

    int          m_rem;
    logic        m_done;
    logic [63:0] m_prod;
    logic [2:0]  m_cf;
    logic [63:0] s_prod;
    logic [2:0]  s_cf;
    logic        m_busy;

    assign m_busy = (m_rem != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_prod <= 64'd0;
            m_cf   <= 3'd0;
            s_prod <= 64'd0;
            s_cf   <= 3'd0;
        end else if (m_rem != 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                m_prod <= s_prod;
                m_cf   <= s_cf;
            end
        end else if (start) begin
            s_prod <= mdl_prod(op_a, op_b);
            s_cf   <= mdl_cf(op_a, op_b);
            m_rem  <= mdl_lat(op_a, op_b) - 1;
            m_done <= (mdl_lat(op_a, op_b) == 1);
            if (mdl_lat(op_a, op_b) == 1) begin
                m_prod <= mdl_prod(op_a, op_b);
                m_cf   <= mdl_cf(op_a, op_b);
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy",    64'(busy),    64'(m_busy));
        chk("cyc_done",    64'(done),    64'(m_done));
        chk("cyc_product", product,      m_prod);
        chk("cyc_cf",      64'(cf),      64'(m_cf));
        if (!m_busy) begin
            chk("cyc_add_a_idle", add_a, 64'd0);
            chk("cyc_add_b_idle", add_b, 64'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_p, input logic [2:0] exp_c,
                          input int exp_lat, input bit back_to_back,
                          input int repulse_at, input string tag);
        int n;
        if (!back_to_back) @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 200) begin
            if (n == repulse_at) begin
                start = 1'b1;
                op_a  = 64'd11;
                op_b  = 64'd13;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_latency"},   64'(n),    64'(exp_lat));
        chk({tag, "_product"},   product,   exp_p);
        chk({tag, "_cf"},        64'(cf),   64'(exp_c));
    endtask

    task automatic count_dones(input int cycles, output int dones);
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = 64'd0;
        op_b  = 64'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_done",    64'(done), 64'd0);
        chk("rst_product", product,   64'd0);
        chk("rst_cf",      64'(cf),   64'd0);
        chk("rst_add_a",   add_a,     64'd0);
        rst_n = 1'b1;

        run_op(64'd3, 64'd5, 64'd15, 3'b000, LAT_FULL, 1'b0, 0, "mul_3x5");
        run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 64'hFFFF_FFFF_FFFF_FFD6, 3'b010,
               LAT_FULL, 1'b0, 0, "mul_m7x6");
        run_op(64'd0, 64'd9, 64'd0, 3'b001, LAT_ZERO, 1'b0, 0, "mul_0x9");
        run_op(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd0, 3'b101,
               LAT_FULL, 1'b0, 0, "mul_2p32sq");
        run_op(64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 3'b010,
               LAT_FULL, 1'b0, 0, "mul_min_x1");
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 3'b110, LAT_FULL, 1'b0, 0, "mul_min_xm1");

        // Start pulsed again mid-sequence must be ignored.
        run_op(64'd100, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FED4, 3'b010,
               LAT_FULL, 1'b0, 10, "mul_repulse");
        count_dones(75, dones);
        chk("repulse_no_extra_done", 64'(dones), 64'd0);

        // Back-to-back: second start issued during the DONE cycle.
        run_op(64'd12, 64'd12, 64'd144, 3'b000, LAT_FULL, 1'b0, 0, "mul_b2b_first");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b000,
               LAT_FULL, 1'b1, 0, "mul_b2b_second");

        // Reset mid-sequence aborts without a done pulse.
        @(negedge clk);
        op_a  = 64'd5;
        op_b  = 64'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy",    64'(busy), 64'd0);
        chk("abort_done",    64'(done), 64'd0);
        chk("abort_product", product,   64'd0);
        chk("abort_cf",      64'(cf),   64'd0);
        chk("abort_add_a",   add_a,     64'd0);
        chk("abort_add_b",   add_b,     64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(80, dones);
        chk("abort_no_done", 64'(dones), 64'd0);
        run_op(64'd2, 64'd2, 64'd4, 3'b000, LAT_FULL, 1'b0, 0, "mul_after_rst");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
